// File: rtl/regfile_op_seq.sv
// -----------------------------------------------------------------------------
// regfile_op_seq
// Operand-fetch / writeback sequencer for the LC-3 register file. Handles one
// operate instruction (ADD, AND, NOT) at a time: reads SR1 and, for the
// register form, SR2 through the single registered read port. It then hands
// both operands to the ALU, waits for the result, writes it to DR and updates
// the NZP condition codes.
//
// Ports
//   clk, rst                   clock, synchronous active-high reset
//   in_valid/in_ready/in_instr instruction handshake from decode
//   rf_rd_sel/rf_rd_data       register file read port (RF_RD_LAT cycles)
//   rf_wr_sel/rf_wr_data/rf_we register file write port (one-cycle pulse)
//   alu_op/alu_a/alu_b/alu_valid   operands to the ALU (00 ADD, 01 AND, 10 NOT)
//   alu_res_valid/alu_res      result from the ALU
//   cc_nzp                     condition codes {N,Z,P}
//   done, err                  writeback-complete / illegal-opcode pulses
// -----------------------------------------------------------------------------
module regfile_op_seq #(
    parameter int RF_RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [15:0] in_instr,
    output logic [2:0]  rf_rd_sel,
    input  logic [15:0] rf_rd_data,
    output logic [2:0]  rf_wr_sel,
    output logic [15:0] rf_wr_data,
    output logic        rf_we,
    output logic [1:0]  alu_op,
    output logic [15:0] alu_a,
    output logic [15:0] alu_b,
    output logic        alu_valid,
    input  logic        alu_res_valid,
    input  logic [15:0] alu_res,
    output logic [2:0]  cc_nzp,
    output logic        done,
    output logic        err
);

    localparam logic [2:0] ST_IDLE = 3'd0;
    localparam logic [2:0] ST_RD_A = 3'd1;
    localparam logic [2:0] ST_RD_B = 3'd2;
    localparam logic [2:0] ST_EXEC = 3'd3;
    localparam logic [2:0] ST_WB   = 3'd4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_AND = 2'b01;
    localparam logic [1:0] OP_NOT = 2'b10;

    // Last value of the read-wait counter: a read phase lasts RF_RD_LAT+1 cycles.
    localparam logic [1:0] RD_LAST = 2'(RF_RD_LAT);

    // Sign-extend the 5-bit immediate of ADD/AND.
    function automatic logic [15:0] sext5(input logic [4:0] imm);
        return {{11{imm[4]}}, imm};
    endfunction

    // Exactly one of N, Z, P is set for any result.
    function automatic logic [2:0] calc_nzp(input logic [15:0] res);
        if (res[15]) begin
            return 3'b100;
        end else if (res == 16'h0000) begin
            return 3'b010;
        end else begin
            return 3'b001;
        end
    endfunction

    logic [2:0]  state_r;
    logic [1:0]  rd_cnt_r;
    logic [2:0]  dr_r;
    logic [2:0]  sr2_r;
    logic        imm_mode_r;
    logic [4:0]  imm5_r;
    logic        in_ready_r;
    logic [2:0]  rf_rd_sel_r;
    logic [2:0]  rf_wr_sel_r;
    logic [15:0] rf_wr_data_r;
    logic        rf_we_r;
    logic [1:0]  alu_op_r;
    logic [15:0] alu_a_r;
    logic [15:0] alu_b_r;
    logic        alu_valid_r;
    logic [2:0]  cc_nzp_r;
    logic        done_r;
    logic        err_r;

    logic        dec_legal_s;
    logic [1:0]  dec_op_s;
    logic        rd_last_s;

    // Decode the opcode of the instruction currently offered.
    always_comb begin
        dec_legal_s = 1'b0;
        dec_op_s    = OP_ADD;
        case (in_instr[15:12])
            4'b0001: begin
                dec_legal_s = 1'b1;
                dec_op_s    = OP_ADD;
            end
            4'b0101: begin
                dec_legal_s = 1'b1;
                dec_op_s    = OP_AND;
            end
            4'b1001: begin
                dec_legal_s = 1'b1;
                dec_op_s    = OP_NOT;
            end
            default: begin
                dec_legal_s = 1'b0;
                dec_op_s    = OP_ADD;
            end
        endcase
    end

    assign rd_last_s = (rd_cnt_r == RD_LAST);

    // Sequencer state machine and all registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= ST_IDLE;
            rd_cnt_r     <= 2'd0;
            dr_r         <= 3'd0;
            sr2_r        <= 3'd0;
            imm_mode_r   <= 1'b0;
            imm5_r       <= 5'd0;
            in_ready_r   <= 1'b0;
            rf_rd_sel_r  <= 3'd0;
            rf_wr_sel_r  <= 3'd0;
            rf_wr_data_r <= 16'h0000;
            rf_we_r      <= 1'b0;
            alu_op_r     <= OP_ADD;
            alu_a_r      <= 16'h0000;
            alu_b_r      <= 16'h0000;
            alu_valid_r  <= 1'b0;
            cc_nzp_r     <= 3'b010;
            done_r       <= 1'b0;
            err_r        <= 1'b0;
        end else begin
            // Pulse outputs fall back to zero unless re-asserted below.
            rf_we_r <= 1'b0;
            done_r  <= 1'b0;
            err_r   <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    in_ready_r <= 1'b1;
                    if (in_valid && in_ready_r) begin
                        if (dec_legal_s) begin
                            dr_r        <= in_instr[11:9];
                            sr2_r       <= in_instr[2:0];
                            imm_mode_r  <= in_instr[5];
                            imm5_r      <= in_instr[4:0];
                            alu_op_r    <= dec_op_s;
                            rf_rd_sel_r <= in_instr[8:6];
                            rd_cnt_r    <= 2'd0;
                            in_ready_r  <= 1'b0;
                            state_r     <= ST_RD_A;
                        end else begin
                            // Rejected opcode: no register file access, stay ready.
                            err_r <= 1'b1;
                        end
                    end
                end
                ST_RD_A: begin
                    if (rd_last_s) begin
                        alu_a_r  <= rf_rd_data;
                        rd_cnt_r <= 2'd0;
                        if (alu_op_r == OP_NOT) begin
                            alu_b_r     <= 16'h0000;
                            alu_valid_r <= 1'b1;
                            state_r     <= ST_EXEC;
                        end else if (imm_mode_r) begin
                            alu_b_r     <= sext5(imm5_r);
                            alu_valid_r <= 1'b1;
                            state_r     <= ST_EXEC;
                        end else begin
                            rf_rd_sel_r <= sr2_r;
                            state_r     <= ST_RD_B;
                        end
                    end else begin
                        rd_cnt_r <= rd_cnt_r + 2'd1;
                    end
                end
                ST_RD_B: begin
                    if (rd_last_s) begin
                        alu_b_r     <= rf_rd_data;
                        rd_cnt_r    <= 2'd0;
                        alu_valid_r <= 1'b1;
                        state_r     <= ST_EXEC;
                    end else begin
                        rd_cnt_r <= rd_cnt_r + 2'd1;
                    end
                end
                ST_EXEC: begin
                    // Writeback outputs are loaded here so they are visible
                    // during the single WB cycle.
                    if (alu_res_valid) begin
                        alu_valid_r  <= 1'b0;
                        rf_we_r      <= 1'b1;
                        rf_wr_sel_r  <= dr_r;
                        rf_wr_data_r <= alu_res;
                        cc_nzp_r     <= calc_nzp(alu_res);
                        done_r       <= 1'b1;
                        state_r      <= ST_WB;
                    end else begin
                        alu_valid_r <= 1'b1;
                    end
                end
                ST_WB: begin
                    in_ready_r <= 1'b1;
                    state_r    <= ST_IDLE;
                end
                default: begin
                    in_ready_r  <= 1'b0;
                    alu_valid_r <= 1'b0;
                    state_r     <= ST_IDLE;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign rf_rd_sel  = rf_rd_sel_r;
    assign rf_wr_sel  = rf_wr_sel_r;
    assign rf_wr_data = rf_wr_data_r;
    assign rf_we      = rf_we_r;
    assign alu_op     = alu_op_r;
    assign alu_a      = alu_a_r;
    assign alu_b      = alu_b_r;
    assign alu_valid  = alu_valid_r;
    assign cc_nzp     = cc_nzp_r;
    assign done       = done_r;
    assign err        = err_r;

endmodule

// File: doc/regfile_op_seq.md
Name: regfile_op_seq

Overview:
- Operand-fetch / writeback sequencer for the LC-3 register file. The register file has one registered read port and one write port.
- Accepts one operate instruction at a time: ADD, AND or NOT.
- Reads SR1, then SR2 when needed, serially through the single read port. Hands operands to the ALU and waits for its result.
- Writes the result to DR and updates the NZP condition codes.
- Sits between the decode stage and the register file / ALU.

Parameters:
- RF_RD_LAT, 1: cycles from the edge that samples rf_rd_sel to the edge where rf_rd_data is valid (1 or 2).

Ports:
- clk  in  1  system clock; all logic is posedge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  instruction offered.
- in_ready  out  1  sequencer can accept an instruction.
- in_instr  in  16  LC-3 instruction word.
- rf_rd_sel  out  3  register file read select.
- rf_rd_data  in  16  register file read data.
- rf_wr_sel  out  3  register file write select.
- rf_wr_data  out  16  register file write data.
- rf_we  out  1  register file write enable, one-cycle pulse.
- alu_op  out  2  00 ADD, 01 AND, 10 NOT.
- alu_a  out  16  operand A.
- alu_b  out  16  operand B.
- alu_valid  out  1  operands valid.
- alu_res_valid  in  1  ALU result valid.
- alu_res  in  16  ALU result.
- cc_nzp  out  3  condition codes {N,Z,P}.
- done  out  1  one-cycle pulse when writeback completes.
- err  out  1  one-cycle pulse when an opcode is rejected.

Behaviour:
- Reset values: in_ready=0 during rst and 1 in the first cycle after; rf_we=0, alu_valid=0, done=0, err=0, cc_nzp=3'b010, rf_rd_sel=0, rf_wr_sel=0, rf_wr_data=0, alu_a=0, alu_b=0, alu_op=0. State goes to IDLE.
- All outputs are registered.
- IDLE:
  - in_ready=1.
  - On in_valid & in_ready, latch in_instr and deassert in_ready on the next cycle.
  - Decode on in_instr[15:12]: 0001 ADD, 0101 AND, 1001 NOT.
  - Any other opcode: err=1 for one cycle, stay in IDLE. There is no register file access.
  - Legal opcode: drive rf_rd_sel=instr[8:6] (SR1) and go to RD_A.
- RD_A:
  - Stays RF_RD_LAT+1 cycles, counted by an internal counter. On the last cycle, capture rf_rd_data into alu_a.
  - Next state:
    - NOT: alu_b=16'h0000, go to EXEC.
    - ADD/AND with instr[5]=1: alu_b=sign-extended instr[4:0] to 16 bits, go to EXEC.
    - ADD/AND with instr[5]=0: drive rf_rd_sel=instr[2:0] (SR2), go to RD_B.
- RD_B: same timing as RD_A; capture into alu_b, go to EXEC.
- Same-register reads: SR1==SR2 (and SR1==DR) are legal and need no special casing; both reads return the same value.
- EXEC:
  - alu_valid=1 and alu_op held stable until the cycle alu_res_valid=1 is sampled.
  - Latch alu_res, drop alu_valid on the next edge, go to WB.
  - No timeout; the sequencer waits indefinitely.
  - alu_res_valid outside EXEC is ignored.
- WB: lasts exactly one cycle.
  - rf_we=1, rf_wr_sel=instr[11:9] (DR), rf_wr_data=latched result.
  - cc_nzp updates on the same edge: N if result[15]; Z if result==0; P otherwise. Exactly one bit is set.
  - done=1. Next state IDLE; in_ready=1 the following cycle.
- Throughput: one instruction in flight. Minimum latency from accept to done:
  - 2*(RF_RD_LAT+1)+3 cycles for register-register ops.
  - (RF_RD_LAT+1)+3 cycles for immediate ops and NOT.
- rst asserted in any state, including EXEC with alu_valid high or WB: the next edge forces the reset values. A pending write is suppressed (rf_we=0 on that edge) and the latched instruction is discarded.
- in_valid while in_ready=0 is ignored. The upstream stage holds in_instr until the handshake completes.

Test Plan:
- Immediate ADD: reset, then apply ADD R3,R1,#-1 (0x167F) with R1 returning 0x0005 and ALU returning 0x0004. Required: rf_rd_sel=1; alu_a=0x0005, alu_b=0xFFFF; one rf_we pulse with sel=3, data=0x0004; cc_nzp=001; done pulses once; no RD_B cycle.
- Register AND: apply AND R2,R4,R5 (0x5505) with R4=0x00F0, R5=0x0F0F, result 0x0000. Required: reads sel 4 then sel 5, each RF_RD_LAT+1 cycles; write R2=0x0000; cc_nzp=010; latency 2*(RF_RD_LAT+1)+3.
- NOT: apply NOT R7,R6 (0x9FBF) with R6=0x7FFF, result 0x8000. Required: alu_op=10, alu_b=0; write sel 7 with 0x8000; cc_nzp=100.
- Illegal opcode: apply 0x0000 (BR). Required: err=1 for one cycle, rf_we never asserted, cc_nzp unchanged, in_ready stays 1.
- ALU stall: hold alu_res_valid=0 for 10 cycles in EXEC. Required: alu_valid, alu_a, alu_b stable throughout; in_valid pulses ignored; writeback occurs 1 cycle after alu_res_valid.
- Reset mid-operation: assert rst on the WB cycle and separately in RD_B. Required: no rf_we on that edge, cc_nzp=010, state IDLE, in_ready=0 during rst and 1 in the first cycle after rst deasserts; a following ADD completes normally.
